vdec_hs_ctrl: RTL and testbench
===============================

Name: vdec_hs_ctrl

Overview:
- Job sequencer for the HS Viterbi decoder (rate 1/3, codeblk 1..29, 8 tail bits).
- Accepts a decode job and starts the forward ACS unit, which writes the path-decision RAM (ptram). It then starts the backward traceback unit, which reads ptram, and returns the masked decoded bits over a valid/ready handshake.
- Owns the single ptram port and multiplexes it between the forward writer and the backward reader.
- Watchdog aborts hung phases.

Parameters:
MAX_BLK, 29, largest legal codeblk_size
TAIL, 8, tail bits appended per block
TIMEOUT, 1023, max cycles allowed in any WAIT state (10-bit watchdog)

Ports:
clk  in  1  clock
rst  in  1  reset
job_valid  in  1  job request
job_ready  out  1  controller can accept job
job_size  in  5  codeblk_size of job
fwd_start  out  1  one-cycle start pulse to forward unit
fwd_len  out  6  trellis stages to run = job_size+TAIL
fwd_done  in  1  forward unit done pulse
fwd_pt_wr  in  1  forward ptram write
fwd_pt_addr  in  9  forward ptram address
fwd_pt_din  in  32  forward ptram data
bwd_start  out  1  one-cycle start pulse to traceback
bwd_last  out  6  last stage index = job_size+TAIL-1
bwd_done  in  1  traceback done pulse
bwd_pt_rd  in  1  traceback ptram read
bwd_pt_addr  in  9  traceback ptram address
bwd_dec_bits  in  29  traceback result, LSB = last decoded bit
pt_wr  out  1  ptram write enable
pt_rd  out  1  ptram read enable
pt_addr  out  9  ptram address
pt_din  out  32  ptram write data
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_bits  out  29  decoded bits, masked to res_size
res_size  out  5  codeblk_size of result
err  out  1  one-cycle error pulse
err_code  out  2  1=bad size, 2=timeout, 3=illegal ptram access; held until next err

Behaviour:
- rst (asynchronous, active-high): state=IDLE; all registered outputs 0, including fwd_start, bwd_start, res_valid, res_bits, res_size, err and err_code.
- job_ready = (state==IDLE), decoded combinationally from the state register.
- FSM states and transitions:
  - IDLE: on job_valid&job_ready, latch job_size.
    - Size 0 or >MAX_BLK: err=1 and err_code=1 next cycle; stay in IDLE.
    - Otherwise go to FWD_GO.
  - FWD_GO: fwd_start=1 for exactly this cycle; then FWD_WAIT.
  - FWD_WAIT: on fwd_done go to BWD_GO.
  - BWD_GO: bwd_start=1 for one cycle; then BWD_WAIT.
  - BWD_WAIT: on bwd_done, register res_bits = bwd_dec_bits & ((1<<size)-1) and res_size; go to OUT.
  - OUT: res_valid=1, with res_bits and res_size stable. On res_ready go to IDLE; res_valid drops the next cycle.
- Latency: job accepted at edge N → fwd_start high in cycle N+1. bwd_done at edge M → res_valid high in cycle M+1.
- fwd_len and bwd_last are held stable from FWD_GO until the job leaves OUT.
- ptram mux is combinational:
  - FWD_GO/FWD_WAIT: pt_wr=fwd_pt_wr; pt_addr=fwd_pt_addr; pt_din=fwd_pt_din; pt_rd=0.
  - BWD_GO/BWD_WAIT: pt_rd=bwd_pt_rd; pt_addr=bwd_pt_addr; pt_wr=0.
  - Other states: pt_wr=pt_rd=0; pt_addr=0.
- Illegal access: fwd_pt_wr outside the FWD states, or bwd_pt_rd outside the BWD states.
  - The access is blocked and err=1, err_code=3 next cycle; the FSM is unaffected.
  - Illegal access and a bad size in the same cycle: bad size (code 1) wins.
- Watchdog:
  - 10-bit counter cleared on entry to FWD_WAIT and to BWD_WAIT; increments each cycle while in them.
  - On reaching TIMEOUT without the done pulse: err=1, err_code=2; go to IDLE; no result is produced.
- A done pulse in the same cycle as the timeout: done wins.
- Stray fwd_done or bwd_done pulses outside their WAIT state are ignored.
- Reset mid-job: immediate return to IDLE; any pending result is discarded.

Optional Feature:
VDEC_HS_CTRL_PERF_EN
- Defined:
  - Adds output perf_cycles [9:0], reset 0.
  - A cycle counter runs from FWD_GO until the OUT entry, saturating at 1023.
  - The count is loaded into perf_cycles on OUT entry and held until the next OUT entry.
- Undefined: port and counter absent; all other behaviour is identical.

Test Plan:
- Size 29 job; fwd_done 40 cycles after fwd_start; bwd_done 45 cycles after bwd_start; res_ready=1 → fwd_len=37, bwd_last=36, res_valid one cycle after bwd_done, res_bits=bwd_dec_bits, res_size=29.
- Size 5 job with bwd_dec_bits=29'h1FFFFFFF → res_bits=29'h1F; with res_ready held 0 for 10 cycles, res_valid holds 10 cycles and job_ready=0 throughout.
- job_size=0, then job_size=30 → each gives err pulse with err_code=1, no fwd_start, job_ready stays 1.
- fwd_done withheld → err pulse, err_code=2 at the TIMEOUT-th cycle of FWD_WAIT; state returns to IDLE; no res_valid.
- bwd_pt_rd=1 during FWD_WAIT → pt_rd=0, err_code=3, job completes normally; during BWD_WAIT pt_addr tracks bwd_pt_addr cycle-for-cycle.
- rst asserted during BWD_WAIT → all outputs 0 asynchronously; after release, a new job runs normally.

Source files
------------

// File: rtl/vdec_hs_ctrl.sv
// HS Viterbi decoder job sequencer: runs forward ACS then traceback,
// shares the single ptram port between them and returns masked bits.
// Ports: clk/rst (async, active-high); job_* request; fwd_*/bwd_*
// unit control and ptram requests; pt_* shared ptram port;
// res_* result handshake; err/err_code error report.
// Optional: VDEC_HS_CTRL_PERF_EN adds perf_cycles[9:0].
`timescale 1ns/1ps
module vdec_hs_ctrl #(
  parameter int MAX_BLK = 29,
  parameter int TAIL    = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [4:0]  job_size,
  output logic        fwd_start,
  output logic [5:0]  fwd_len,
  input  logic        fwd_done,
  input  logic        fwd_pt_wr,
  input  logic [8:0]  fwd_pt_addr,
  input  logic [31:0] fwd_pt_din,
  output logic        bwd_start,
  output logic [5:0]  bwd_last,
  input  logic        bwd_done,
  input  logic        bwd_pt_rd,
  input  logic [8:0]  bwd_pt_addr,
  input  logic [28:0] bwd_dec_bits,
  output logic        pt_wr,
  output logic        pt_rd,
  output logic [8:0]  pt_addr,
  output logic [31:0] pt_din,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [28:0] res_bits,
  output logic [4:0]  res_size,
`ifdef VDEC_HS_CTRL_PERF_EN
  output logic [9:0]  perf_cycles,
`endif
  output logic        err,
  output logic [1:0]  err_code
);

  localparam logic [4:0] MAXB    = 5'(MAX_BLK);
  localparam logic [5:0] TAIL6   = 6'(TAIL);
  // WAIT states last at most TIMEOUT cycles
  localparam logic [9:0] WD_LAST = 10'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FWD_GO, S_FWD_WAIT,
    S_BWD_GO, S_BWD_WAIT, S_OUT
  } state_t;

  state_t      st, nxt;
  logic [4:0]  job_sz;
  logic [9:0]  wd;
  logic        ld_job, ld_res;
  logic        bad_sz, tmo, ill;
  logic        in_fwd, in_bwd;
  logic [28:0] mask;

  assign job_ready = (st == S_IDLE);
  assign in_fwd = (st == S_FWD_GO) || (st == S_FWD_WAIT);
  assign in_bwd = (st == S_BWD_GO) || (st == S_BWD_WAIT);
  assign ill = (fwd_pt_wr && !in_fwd) ||
               (bwd_pt_rd && !in_bwd);
  // 29-bit wrap makes size 29 yield an all-ones mask
  assign mask = (29'd1 << job_sz) - 29'd1;

  always_comb begin
    nxt    = st;
    ld_job = 1'b0;
    ld_res = 1'b0;
    bad_sz = 1'b0;
    tmo    = 1'b0;
    unique case (st)
      S_IDLE:
        if (job_valid) begin
          if (job_size == 5'd0 || job_size > MAXB)
            bad_sz = 1'b1;
          else begin
            nxt    = S_FWD_GO;
            ld_job = 1'b1;
          end
        end
      S_FWD_GO: nxt = S_FWD_WAIT;
      S_FWD_WAIT:
        if (fwd_done) nxt = S_BWD_GO;
        else if (wd == WD_LAST) begin
          tmo = 1'b1;
          nxt = S_IDLE;
        end
      S_BWD_GO: nxt = S_BWD_WAIT;
      S_BWD_WAIT:
        if (bwd_done) begin
          nxt    = S_OUT;
          ld_res = 1'b1;
        end else if (wd == WD_LAST) begin
          tmo = 1'b1;
          nxt = S_IDLE;
        end
      S_OUT:
        if (res_ready) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    pt_wr   = 1'b0;
    pt_rd   = 1'b0;
    pt_addr = '0;
    pt_din  = '0;
    if (in_fwd) begin
      pt_wr   = fwd_pt_wr;
      pt_addr = fwd_pt_addr;
      pt_din  = fwd_pt_din;
    end else if (in_bwd) begin
      pt_rd   = bwd_pt_rd;
      pt_addr = bwd_pt_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= S_IDLE;
      job_sz    <= '0;
      wd        <= '0;
      fwd_start <= 1'b0;
      bwd_start <= 1'b0;
      fwd_len   <= '0;
      bwd_last  <= '0;
      res_valid <= 1'b0;
      res_bits  <= '0;
      res_size  <= '0;
      err       <= 1'b0;
      err_code  <= '0;
    end else begin
      st        <= nxt;
      fwd_start <= (nxt == S_FWD_GO);
      bwd_start <= (nxt == S_BWD_GO);
      res_valid <= (nxt == S_OUT);
      // GO states always lead into WAIT
      if (st == S_FWD_GO || st == S_BWD_GO)
        wd <= '0;
      else if (st == S_FWD_WAIT || st == S_BWD_WAIT)
        wd <= wd + 10'd1;
      if (ld_job) begin
        job_sz   <= job_size;
        fwd_len  <= 6'(job_size) + TAIL6;
        bwd_last <= 6'(job_size) + TAIL6 - 6'd1;
      end
      if (ld_res) begin
        res_bits <= bwd_dec_bits & mask;
        res_size <= job_sz;
      end
      err <= bad_sz || tmo || ill;
      if (bad_sz)   err_code <= 2'd1;
      else if (tmo) err_code <= 2'd2;
      else if (ill) err_code <= 2'd3;
    end
  end

`ifdef VDEC_HS_CTRL_PERF_EN
  logic [9:0] pc, pc_inc;
  assign pc_inc = (pc == 10'h3FF) ? pc : pc + 10'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= '0;
      perf_cycles <= '0;
    end else begin
      if (ld_job) pc <= '0;
      else if (in_fwd || in_bwd) pc <= pc_inc;
      if ((in_fwd || in_bwd) && nxt == S_OUT)
        perf_cycles <= pc_inc;
    end
  end
`endif

endmodule

// File: tb/tb_vdec_hs_ctrl.sv
// Self-checking bench for vdec_hs_ctrl: directed scenarios plus
// randomized jobs checked against a job-level expectation model.
`timescale 1ns/1ps
module tb_vdec_hs_ctrl;
  localparam int TMO = 1023;

  logic        clk = 1'b0;
  logic        rst;
  logic        job_valid, job_ready;
  logic [4:0]  job_size;
  logic        fwd_start, fwd_done, fwd_pt_wr;
  logic [5:0]  fwd_len, bwd_last;
  logic [8:0]  fwd_pt_addr, bwd_pt_addr, pt_addr;
  logic [31:0] fwd_pt_din, pt_din;
  logic        bwd_start, bwd_done, bwd_pt_rd;
  logic [28:0] bwd_dec_bits, res_bits;
  logic        pt_wr, pt_rd;
  logic        res_valid, res_ready;
  logic [4:0]  res_size;
  logic        err;
  logic [1:0]  err_code;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vdec_hs_ctrl dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_size(job_size),
    .fwd_start(fwd_start), .fwd_len(fwd_len),
    .fwd_done(fwd_done), .fwd_pt_wr(fwd_pt_wr),
    .fwd_pt_addr(fwd_pt_addr), .fwd_pt_din(fwd_pt_din),
    .bwd_start(bwd_start), .bwd_last(bwd_last),
    .bwd_done(bwd_done), .bwd_pt_rd(bwd_pt_rd),
    .bwd_pt_addr(bwd_pt_addr), .bwd_dec_bits(bwd_dec_bits),
    .pt_wr(pt_wr), .pt_rd(pt_rd),
    .pt_addr(pt_addr), .pt_din(pt_din),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_bits(res_bits), .res_size(res_size),
    .err(err), .err_code(err_code)
  );

  task automatic clear_inputs;
    job_valid = 0; job_size = 0;
    fwd_done = 0; fwd_pt_wr = 0;
    fwd_pt_addr = 0; fwd_pt_din = 0;
    bwd_done = 0; bwd_pt_rd = 0;
    bwd_pt_addr = 0; bwd_dec_bits = 0;
    res_ready = 0;
  endtask

  // One complete job; fl/bl = cycles in FWD_WAIT/BWD_WAIT up to
  // and including the done pulse; hold = cycles res_valid stays up.
  task automatic run_job(input int sz, input int fl,
                         input int bl, input int hold,
                         input logic [28:0] dec,
                         input bit inj);
    longint    e;
    logic [28:0] exp_bits;
    bit        exp_err;
    e = longint'(dec) % (longint'(1) << sz);
    exp_bits = e[28:0];
    job_valid = 1; job_size = 5'(sz);
    #1;
    tests++;
    if (job_ready !== 1'b1) begin
      fails++;
      $display("FAIL job_accept: job_ready=%b want 1", job_ready);
    end
    @(negedge clk);
    job_valid = 0;
    tests++;
    if (fwd_start !== 1'b1 || fwd_len !== 6'(sz + 8) ||
        job_ready !== 1'b0) begin
      fails++;
      $display("FAIL fwd_go: start=%b len=%0d rdy=%b want 1 %0d 0",
               fwd_start, fwd_len, job_ready, sz + 8);
    end
    for (int k = 1; k <= fl; k++) begin
      @(negedge clk);
      exp_err = inj && k == 2;
      if (inj && k == 2) bwd_pt_rd = 0;
      tests++;
      if (err !== exp_err ||
          (exp_err && err_code !== 2'd3)) begin
        fails++;
        $display("FAIL fwd_err k=%0d: err=%b code=%0d want %b 3",
                 k, err, err_code, exp_err);
      end
      fwd_pt_wr = 1'($urandom);
      fwd_pt_addr = 9'($urandom);
      fwd_pt_din = $urandom;
      if (inj && k == 1) bwd_pt_rd = 1;
      fwd_done = (k == fl);
      #1;
      tests++;
      if (pt_wr !== fwd_pt_wr || pt_addr !== fwd_pt_addr ||
          pt_din !== fwd_pt_din || pt_rd !== 1'b0) begin
        fails++;
        $display("FAIL fwd_mux k=%0d: wr=%b a=%h rd=%b want %b %h 0",
                 k, pt_wr, pt_addr, pt_rd, fwd_pt_wr, fwd_pt_addr);
      end
    end
    @(negedge clk);
    fwd_done = 0; fwd_pt_wr = 0; bwd_pt_rd = 0;
    bwd_dec_bits = dec;
    tests++;
    if (bwd_start !== 1'b1 || bwd_last !== 6'(sz + 7) ||
        fwd_len !== 6'(sz + 8) || err !== 1'b0) begin
      fails++;
      $display("FAIL bwd_go: start=%b last=%0d err=%b want 1 %0d 0",
               bwd_start, bwd_last, err, sz + 7);
    end
    for (int k = 1; k <= bl; k++) begin
      @(negedge clk);
      bwd_pt_rd = 1'($urandom);
      bwd_pt_addr = 9'($urandom);
      bwd_done = (k == bl);
      #1;
      tests++;
      if (pt_rd !== bwd_pt_rd || pt_addr !== bwd_pt_addr ||
          pt_wr !== 1'b0 || res_valid !== 1'b0) begin
        fails++;
        $display("FAIL bwd_mux k=%0d: rd=%b a=%h wr=%b want %b %h 0",
                 k, pt_rd, pt_addr, pt_wr, bwd_pt_rd, bwd_pt_addr);
      end
    end
    @(negedge clk);
    bwd_done = 0; bwd_pt_rd = 0;
    bwd_dec_bits = 29'($urandom);
    #1;
    tests++;
    if (res_valid !== 1'b1 || res_bits !== exp_bits ||
        res_size !== 5'(sz) || job_ready !== 1'b0 ||
        pt_addr !== 9'd0) begin
      fails++;
      $display("FAIL result: v=%b bits=%h sz=%0d a=%h want 1 %h %0d 0",
               res_valid, res_bits, res_size, pt_addr, exp_bits, sz);
    end
    for (int h = 1; h < hold; h++) begin
      @(negedge clk);
      bwd_dec_bits = 29'($urandom);
      tests++;
      if (res_valid !== 1'b1 || res_bits !== exp_bits ||
          res_size !== 5'(sz) || job_ready !== 1'b0) begin
        fails++;
        $display("FAIL hold h=%0d: v=%b bits=%h rdy=%b want 1 %h 0",
                 h, res_valid, res_bits, job_ready, exp_bits);
      end
    end
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
    tests++;
    if (res_valid !== 1'b0 || job_ready !== 1'b1) begin
      fails++;
      $display("FAIL release: v=%b rdy=%b want 0 1",
               res_valid, job_ready);
    end
  endtask

  task automatic test_reset;
    clear_inputs();
    rst = 1;
    repeat (2) @(negedge clk);
    tests++;
    if ({fwd_start, bwd_start, res_valid, res_bits, res_size,
         err, err_code, fwd_len, bwd_last} !== '0 ||
        job_ready !== 1'b1 || pt_wr !== 1'b0 ||
        pt_rd !== 1'b0 || pt_addr !== 9'd0) begin
      fails++;
      $display("FAIL reset: outputs not idle (rdy=%b err=%b v=%b)",
               job_ready, err, res_valid);
    end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_max_size;
    run_job(29, 40, 45, 1, 29'($urandom), 0);
  endtask

  task automatic test_backpressure;
    run_job(5, 3, 4, 10, 29'h1FFFFFFF, 0);
  endtask

  task automatic test_bad_size;
    int bad [3] = '{0, 30, 31};
    for (int i = 0; i < 3; i++) begin
      job_valid = 1; job_size = 5'(bad[i]);
      fwd_pt_wr = (bad[i] == 31);
      @(negedge clk);
      job_valid = 0; fwd_pt_wr = 0;
      tests++;
      if (err !== 1'b1 || err_code !== 2'd1 ||
          fwd_start !== 1'b0 || job_ready !== 1'b1) begin
        fails++;
        $display("FAIL bad_size %0d: err=%b code=%0d st=%b rdy=%b",
                 bad[i], err, err_code, fwd_start, job_ready);
      end
      @(negedge clk);
      tests++;
      if (err !== 1'b0 || err_code !== 2'd1 ||
          fwd_start !== 1'b0) begin
        fails++;
        $display("FAIL bad_size_after %0d: err=%b code=%0d want 0 1",
                 bad[i], err, err_code);
      end
    end
  endtask

  task automatic test_timeout;
    bit bad;
    job_valid = 1; job_size = 5'd10;
    @(negedge clk);
    job_valid = 0;
    bad = 0;
    for (int k = 1; k <= TMO; k++) begin
      @(negedge clk);
      if (err !== 1'b0 || job_ready !== 1'b0) bad = 1;
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL timeout_early: err/job_ready before limit");
    end
    @(negedge clk);
    tests++;
    if (err !== 1'b1 || err_code !== 2'd2 ||
        job_ready !== 1'b1) begin
      fails++;
      $display("FAIL timeout: err=%b code=%0d rdy=%b want 1 2 1",
               err, err_code, job_ready);
    end
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (res_valid !== 1'b0 || bwd_start !== 1'b0) bad = 1;
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL timeout_after: result or bwd_start seen");
    end
    // done on the last permitted cycle must win
    run_job(7, TMO, 2, 1, 29'($urandom), 0);
  endtask

  task automatic test_illegal;
    fwd_pt_wr = 1; fwd_pt_addr = 9'h055;
    #1;
    tests++;
    if (pt_wr !== 1'b0 || pt_addr !== 9'd0) begin
      fails++;
      $display("FAIL illegal_block: wr=%b a=%h want 0 0",
               pt_wr, pt_addr);
    end
    @(negedge clk);
    fwd_pt_wr = 0;
    tests++;
    if (err !== 1'b1 || err_code !== 2'd3) begin
      fails++;
      $display("FAIL illegal_idle: err=%b code=%0d want 1 3",
               err, err_code);
    end
    run_job(17, 5, 4, 1, 29'($urandom), 1);
  endtask

  task automatic test_stray;
    fwd_done = 1; bwd_done = 1;
    @(negedge clk);
    fwd_done = 0; bwd_done = 0;
    @(negedge clk);
    tests++;
    if (fwd_start !== 1'b0 || bwd_start !== 1'b0 ||
        res_valid !== 1'b0 || job_ready !== 1'b1 ||
        err !== 1'b0) begin
      fails++;
      $display("FAIL stray: fs=%b bs=%b v=%b rdy=%b err=%b",
               fwd_start, bwd_start, res_valid, job_ready, err);
    end
  endtask

  task automatic test_reset_mid;
    job_valid = 1; job_size = 5'd12;
    @(negedge clk);
    job_valid = 0;
    repeat (3) @(negedge clk);
    fwd_done = 1;
    @(negedge clk);
    fwd_done = 0;
    @(negedge clk);
    bwd_pt_rd = 1; bwd_pt_addr = 9'h1A5;
    @(negedge clk);
    rst = 1;
    #1;
    tests++;
    if ({fwd_start, bwd_start, res_valid, res_bits, res_size,
         err, err_code, fwd_len, bwd_last} !== '0 ||
        job_ready !== 1'b1 || pt_rd !== 1'b0 ||
        pt_addr !== 9'd0) begin
      fails++;
      $display("FAIL reset_mid: len=%0d rd=%b a=%h rdy=%b",
               fwd_len, pt_rd, pt_addr, job_ready);
    end
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    run_job(9, 6, 6, 2, 29'($urandom), 0);
  endtask

  task automatic test_random;
    int sz, fl, bl, hd;
    bit inj;
    for (int j = 0; j < 10; j++) begin
      sz = $urandom_range(1, 29);
      fl = $urandom_range(1, 20);
      bl = $urandom_range(1, 20);
      hd = $urandom_range(1, 4);
      inj = (fl >= 2) && ($urandom_range(0, 1) == 1);
      run_job(sz, fl, bl, hd, 29'($urandom), inj);
    end
  endtask

  task automatic test_back_to_back;
    run_job(1, 1, 1, 1, 29'h1FFFFFFF, 0);
    run_job(28, 2, 1, 1, 29'h1FFFFFFF, 0);
  endtask

  initial begin
    test_reset();
    test_max_size();
    test_backpressure();
    test_bad_size();
    test_stray();
    test_illegal();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
